// File: rtl/demux1n2_24bit_buf.sv
// Registered 1-to-2 demultiplexer: steers each producer word, chosen by Sel,
// into one of two independent 2-entry FIFOs, each draining to its own consumer.
// InReady looks only at the selected channel's registered occupancy, so a
// stall on one channel never blocks traffic routed to the other.
module demux1n2_24bit_buf #(
  parameter int WIDTH = 24
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  input  logic             Sel,
  output logic             Out0Valid,
  input  logic             Out0Ready,
  output logic [WIDTH-1:0] Out0Data,
  output logic             Out1Valid,
  input  logic             Out1Ready,
  output logic [WIDTH-1:0] Out1Data,
  output logic [7:0]       Count0,
  output logic [7:0]       Count1
);

  // Per-channel state, indexed [channel]; storage indexed [channel][entry]
  logic [1:0][1:0][WIDTH-1:0] mem_q, mem_d;
  logic [1:0]                 rd_ptr_q, rd_ptr_d;
  logic [1:0]                 wr_ptr_q, wr_ptr_d;
  logic [1:0][1:0]            occ_q, occ_d;
  logic [1:0][7:0]            cnt_q, cnt_d;

  logic                       push;
  logic [1:0]                 push_ch;
  logic [1:0]                 pop;
  logic [1:0]                 sel_occ;

  // Handshake decode: ready depends only on registered occupancy and Sel
  always_comb begin
    sel_occ   = Sel ? occ_q[1] : occ_q[0];
    InReady   = !Reset && (sel_occ != 2'd2);
    push      = InValid && InReady;
    push_ch   = {push && Sel, push && !Sel};
    Out0Valid = (occ_q[0] != 2'd0);
    Out1Valid = (occ_q[1] != 2'd0);
    Out0Data  = Out0Valid ? mem_q[0][rd_ptr_q[0]] : '0;
    Out1Data  = Out1Valid ? mem_q[1][rd_ptr_q[1]] : '0;
    pop       = {Out1Valid && Out1Ready, Out0Valid && Out0Ready};
    Count0    = cnt_q[0];
    Count1    = cnt_q[1];
  end

  // Next-state for both FIFOs; a push and a pop in the same cycle cancel in
  // the occupancy while both pointers advance, preserving order
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    for (int c = 0; c < 2; c++) begin
      if (push_ch[c]) begin
        mem_d[c][wr_ptr_q[c]] = InData;
        wr_ptr_d[c]           = ~wr_ptr_q[c];
        cnt_d[c]              = cnt_q[c] + 8'd1;
      end
      if (pop[c]) begin
        rd_ptr_d[c] = ~rd_ptr_q[c];
      end
      occ_d[c] = occ_q[c] + {1'b0, push_ch[c]} - {1'b0, pop[c]};
    end
  end

  // State registers; reset discards any words in flight
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_demux1n2_24bit_buf.sv
// Self-checking bench for demux1n2_24bit_buf: directed scenarios followed by
// random traffic, checked against a queue-based model of the two channels.
module tb_demux1n2_24bit_buf;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [23:0] InData;
  logic        Sel;
  logic        Out0Valid, Out0Ready;
  logic [23:0] Out0Data;
  logic        Out1Valid, Out1Ready;
  logic [23:0] Out1Data;
  logic [7:0]  Count0, Count1;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: one queue per channel plus accepted-word counters
  logic [23:0] mq0[$];
  logic [23:0] mq1[$];
  logic [7:0]  mc0, mc1;

  demux1n2_24bit_buf #(.WIDTH(24)) dut (
    .Clock(Clock), .Reset(Reset),
    .InValid(InValid), .InReady(InReady), .InData(InData), .Sel(Sel),
    .Out0Valid(Out0Valid), .Out0Ready(Out0Ready), .Out0Data(Out0Data),
    .Out1Valid(Out1Valid), .Out1Ready(Out1Ready), .Out1Data(Out1Data),
    .Count0(Count0), .Count1(Count1)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq0.delete();
    mq1.delete();
    mc0 = 8'd0;
    mc1 = 8'd0;
  endtask

  task automatic check_model(input string tag);
    int occ_sel;
    occ_sel = Sel ? mq1.size() : mq0.size();
    check({tag, ".in_ready"},   {31'd0, InReady},   {31'd0, occ_sel < 2});
    check({tag, ".out0_valid"}, {31'd0, Out0Valid}, {31'd0, mq0.size() != 0});
    check({tag, ".out0_data"},  {8'd0, Out0Data},   {8'd0, (mq0.size() != 0) ? mq0[0] : 24'd0});
    check({tag, ".out1_valid"}, {31'd0, Out1Valid}, {31'd0, mq1.size() != 0});
    check({tag, ".out1_data"},  {8'd0, Out1Data},   {8'd0, (mq1.size() != 0) ? mq1[0] : 24'd0});
    check({tag, ".count0"},     {24'd0, Count0},    {24'd0, mc0});
    check({tag, ".count1"},     {24'd0, Count1},    {24'd0, mc1});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".in_ready"},   {31'd0, InReady},   32'd0);
    check({tag, ".out0_valid"}, {31'd0, Out0Valid}, 32'd0);
    check({tag, ".out0_data"},  {8'd0, Out0Data},   32'd0);
    check({tag, ".out1_valid"}, {31'd0, Out1Valid}, 32'd0);
    check({tag, ".out1_data"},  {8'd0, Out1Data},   32'd0);
    check({tag, ".count0"},     {24'd0, Count0},    32'd0);
    check({tag, ".count1"},     {24'd0, Count1},    32'd0);
  endtask

  // One clock cycle: drive at negedge, check model just after, update at posedge
  task automatic cycle(input logic v, input logic s, input logic [23:0] d,
                       input logic r0, input logic r1);
    bit acc, p0, p1;
    @(negedge Clock);
    InValid = v; Sel = s; InData = d; Out0Ready = r0; Out1Ready = r1;
    #1;
    check_model("cyc");
    acc = v && ((s ? mq1.size() : mq0.size()) < 2);
    p0  = (mq0.size() != 0) && r0;
    p1  = (mq1.size() != 0) && r1;
    @(posedge Clock);
    if (p0) void'(mq0.pop_front());
    if (p1) void'(mq1.pop_front());
    if (acc) begin
      if (s) begin mq1.push_back(d); mc1++; end
      else   begin mq0.push_back(d); mc0++; end
    end
  endtask

  task automatic async_reset(input string tag);
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    InValid = 1'b0;
    #1;
    check_reset_vals(tag);
    model_clear();
    @(negedge Clock);
    #2;
    Reset = 1'b0;
    Sel = 1'b0;
    #1;
    check_model({tag, "_release"});
  endtask

  initial begin
    Reset = 1'b1; InValid = 1'b0; InData = '0; Sel = 1'b0;
    Out0Ready = 1'b0; Out1Ready = 1'b0;
    model_clear();
    repeat (2) @(posedge Clock);
    #2;
    check_reset_vals("por");
    async_reset("reset");

    // Routing
    cycle(1'b1, 1'b0, 24'hABCDEF, 1'b1, 1'b1);
    #3;
    check("route.out0_data", {8'd0, Out0Data}, 32'h00ABCDEF);
    check("route.out1_valid", {31'd0, Out1Valid}, 32'd0);
    cycle(1'b1, 1'b1, 24'h123456, 1'b1, 1'b1);
    #3;
    check("route.out1_data", {8'd0, Out1Data}, 32'h00123456);
    check("route.out0_valid", {31'd0, Out0Valid}, 32'd0);
    check("route.count0", {24'd0, Count0}, 32'd1);
    check("route.count1", {24'd0, Count1}, 32'd1);
    cycle(1'b0, 1'b0, 24'h0, 1'b1, 1'b1);

    // Backpressure on channel 0
    cycle(1'b1, 1'b0, 24'h000001, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 24'h000002, 1'b0, 1'b1);
    #3;
    check("full.in_ready", {31'd0, InReady}, 32'd0);
    cycle(1'b1, 1'b0, 24'h000003, 1'b0, 1'b1);
    // Independence: channel 1 accepts while channel 0 is full and stalled
    cycle(1'b1, 1'b1, 24'h0F0F0F, 1'b0, 1'b1);
    #3;
    check("indep.out1_valid", {31'd0, Out1Valid}, 32'd1);
    check("indep.out1_data", {8'd0, Out1Data}, 32'h000F0F0F);
    check("indep.out0_data", {8'd0, Out0Data}, 32'h00000001);
    cycle(1'b1, 1'b0, 24'h000003, 1'b1, 1'b1);
    #3;
    check("drain.out0_data2", {8'd0, Out0Data}, 32'h00000002);
    cycle(1'b1, 1'b0, 24'h000003, 1'b1, 1'b1);
    #3;
    check("drain.out0_data3", {8'd0, Out0Data}, 32'h00000003);
    cycle(1'b0, 1'b0, 24'h0, 1'b1, 1'b1);

    // Simultaneous push and pop at occupancy 1
    cycle(1'b1, 1'b0, 24'h111111, 1'b0, 1'b1);
    #3;
    check("simul.head_before", {8'd0, Out0Data}, 32'h00111111);
    cycle(1'b1, 1'b0, 24'h222222, 1'b1, 1'b1);
    #3;
    check("simul.head_after", {8'd0, Out0Data}, 32'h00222222);
    check("simul.valid", {31'd0, Out0Valid}, 32'd1);
    cycle(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 24'h0, 1'b1, 1'b1);

    // Counter wrap on channel 1
    async_reset("wrap_rst");
    for (int i = 0; i < 255; i++) cycle(1'b1, 1'b1, 24'(i), 1'b1, 1'b1);
    #3;
    check("wrap.count1_255", {24'd0, Count1}, 32'd255);
    cycle(1'b1, 1'b1, 24'hFFFFFF, 1'b1, 1'b1);
    #3;
    check("wrap.count1_0", {24'd0, Count1}, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end

    // Reset with both FIFOs partly filled; no stale word afterwards
    cycle(1'b1, 1'b0, 24'hA5A5A5, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 24'h5A5A5A, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 24'hC3C3C3, 1'b0, 1'b0);
    async_reset("midop");
    repeat (4) cycle(1'b0, 1'b0, 24'h0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
